// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between a 32-bit hart
// data port and a 512-bit line-wide memory bus. Requests that fall in the
// 16-byte MMIO window are left alone so another responder can answer.
module dcache_wb #(
  parameter int          NUM_LINES = 16,
  parameter logic [31:0] MMIO_BASE = 32'h0000_C000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_addr_valid,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_write_data_valid,
  input  logic [31:0]  cpu_write_data,
  output logic         cpu_read_data_ready,
  output logic [31:0]  cpu_read_data,
  output logic         mem_addr_valid,
  output logic [31:0]  mem_addr,
  output logic         mem_write_data_valid,
  output logic [511:0] mem_write_data,
  input  logic         mem_read_data_ready,
  input  logic [511:0] mem_read_data
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 26 - IW;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [31:2]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TW-1:0]       tag_q  [NUM_LINES];
  logic [511:0]        data_q [NUM_LINES];

  logic                line_we;
  logic [511:0]        line_d;
  logic [3:0]          req_off;
  logic [IW-1:0]       req_idx;
  logic [TW-1:0]       req_tag;
  logic                hit;
  logic                unused_addr_lsbs;

  // Byte-lane bits are meaningless for word-only accesses.
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign req_off = addr_q[5:2];
  assign req_idx = addr_q[6 +: IW];
  assign req_tag = addr_q[31:6+IW];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  function automatic logic [31:0] get_word(input logic [511:0] line, input logic [3:0] off);
    return line[{off, 5'b0} +: 32];
  endfunction

  function automatic logic [511:0] merge_word(input logic [511:0] line, input logic [3:0] off,
                                              input logic [31:0] word);
    logic [511:0] res;
    res = line;
    res[{off, 5'b0} +: 32] = word;
    return res;
  endfunction

  // Next-state, request latching and line-update control.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_we = 1'b0;
    line_d  = data_q[req_idx];
    case (state_q)
      IDLE: begin
        if (cpu_addr_valid && (cpu_addr[31:4] != MMIO_BASE[31:4])) begin
          addr_d  = cpu_addr[31:2];
          wr_d    = cpu_write_data_valid;
          wdata_d = cpu_write_data;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (wr_q) begin
            line_we          = 1'b1;
            line_d           = merge_word(data_q[req_idx], req_off, wdata_q);
            dirty_d[req_idx] = 1'b1;
            rdata_d          = wdata_q;
          end else begin
            rdata_d = get_word(data_q[req_idx], req_off);
          end
          state_d = RESP;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        if (mem_read_data_ready) begin
          dirty_d[req_idx] = 1'b0;
          state_d          = FILL;
        end
      end
      FILL: begin
        if (mem_read_data_ready) begin
          line_we          = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = wr_q;
          if (wr_q) begin
            line_d  = merge_word(mem_read_data, req_off, wdata_q);
            rdata_d = wdata_q;
          end else begin
            line_d  = mem_read_data;
            rdata_d = get_word(mem_read_data, req_off);
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, request kind and per-line valid/dirty bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Datapath registers: latched request and response word.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Line storage; the tag only changes when a new line is installed.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[req_idx] <= line_d;
    end
    if (line_we && (state_q == FILL)) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  // Memory-bus outputs are zero whenever no external transaction is running.
  always_comb begin
    mem_addr_valid       = 1'b0;
    mem_addr             = 32'h0;
    mem_write_data_valid = 1'b0;
    mem_write_data       = '0;
    case (state_q)
      WRITEBACK: begin
        mem_addr_valid       = 1'b1;
        mem_write_data_valid = 1'b1;
        mem_addr             = {tag_q[req_idx], req_idx, 6'b0};
        mem_write_data       = data_q[req_idx];
      end
      FILL: begin
        mem_addr_valid = 1'b1;
        mem_addr       = {addr_q[31:6], 6'b0};
      end
      default: begin
      end
    endcase
  end

  // The CPU response wires are shared, so release them unless responding.
  assign cpu_read_data_ready = (state_q == RESP) ? 1'b1    : 1'bz;
  assign cpu_read_data       = (state_q == RESP) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a line-granular memory responder that
// stores written-back lines and returns a fixed pattern for untouched lines.
module tb_dcache_wb;

  logic         clk;
  logic         rst;
  logic         cpu_addr_valid;
  logic [31:0]  cpu_addr;
  logic         cpu_write_data_valid;
  logic [31:0]  cpu_write_data;
  wire          cpu_read_data_ready;
  wire  [31:0]  cpu_read_data;
  logic         mem_addr_valid;
  logic [31:0]  mem_addr;
  logic         mem_write_data_valid;
  logic [511:0] mem_write_data;
  logic         mem_read_data_ready;
  logic [511:0] mem_read_data;

  dcache_wb #(.NUM_LINES(16), .MMIO_BASE(32'h0000_C000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cpu_addr_valid       (cpu_addr_valid),
    .cpu_addr             (cpu_addr),
    .cpu_write_data_valid (cpu_write_data_valid),
    .cpu_write_data       (cpu_write_data),
    .cpu_read_data_ready  (cpu_read_data_ready),
    .cpu_read_data        (cpu_read_data),
    .mem_addr_valid       (mem_addr_valid),
    .mem_addr             (mem_addr),
    .mem_write_data_valid (mem_write_data_valid),
    .mem_write_data       (mem_write_data),
    .mem_read_data_ready  (mem_read_data_ready),
    .mem_read_data        (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Memory responder state and transaction log.
  logic [511:0] store [logic [25:0]];
  int           mem_delay = 0;
  int           wcnt = 0;
  bit           in_txn = 0;
  int           n_txn = 0;
  int           stab_err = 0;
  logic [31:0]  txn_addr = 0;
  logic         txn_wr = 0;
  logic [31:0]  wb_addr = 0;
  logic [511:0] wb_data = 0;
  logic [31:0]  fill_addr = 32'hFFFF_FFFF;

  function automatic logic [511:0] fill_line(input logic [31:0] a);
    logic [511:0] l;
    logic [25:0]  k;
    k = a[31:6];
    if (store.exists(k)) return store[k];
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {a[31:6], w[3:0], 2'b00} ^ 32'h5A00_0000;
    if (k == 26'd0) l[159:128] = 32'hDEAD_BEEF;
    return l;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      mem_read_data_ready = 1'b0;
      wcnt = 0;
      in_txn = 0;
    end else if (mem_read_data_ready) begin
      mem_read_data_ready = 1'b0;
      in_txn = 0;
      wcnt = 0;
    end else if (mem_addr_valid === 1'b1) begin
      if (!in_txn) begin
        in_txn = 1;
        wcnt = 0;
        n_txn++;
        txn_addr = mem_addr;
        txn_wr = mem_write_data_valid;
        if (txn_wr) begin
          wb_addr = mem_addr;
          wb_data = mem_write_data;
        end else begin
          fill_addr = mem_addr;
        end
      end else if (mem_addr !== txn_addr || mem_write_data_valid !== txn_wr) begin
        stab_err++;
      end
      if (wcnt >= mem_delay) begin
        mem_read_data_ready = 1'b1;
        if (txn_wr) store[mem_addr[31:6]] = mem_write_data;
        else mem_read_data = fill_line(mem_addr);
      end else begin
        wcnt++;
      end
    end else if (in_txn) begin
      stab_err++;
      in_txn = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] rd, output int cycles, output bit got);
    @(negedge clk);
    cpu_addr_valid       = 1'b1;
    cpu_addr             = a;
    cpu_write_data_valid = w;
    cpu_write_data       = d;
    cycles = 0;
    got    = 0;
    rd     = 32'h0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cpu_read_data_ready === 1'b1) begin
        got = 1;
        rd  = cpu_read_data;
      end
    end
    cpu_addr_valid       = 1'b0;
    cpu_write_data_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int          cyc;
  bit          got;
  int          t0;

  initial begin
    rst = 1'b0;
    cpu_addr_valid = 1'b0;
    cpu_addr = 32'h0;
    cpu_write_data_valid = 1'b0;
    cpu_write_data = 32'h0;
    mem_read_data_ready = 1'b0;
    mem_read_data = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_mem_valid", 64'(mem_addr_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wr", 64'(mem_write_data_valid), 64'd0);
    check("rst_mem_wdata_lo", mem_write_data[63:0], 64'd0);
    check("rst_ready_idle", 64'(cpu_read_data_ready === 1'b1), 64'd0);
    rst = 1'b1;

    // Cold read miss of 0x10, then a hit.
    t0 = n_txn;
    cpu_req(32'h0000_0010, 1'b0, 32'h0, rd, cyc, got);
    check("miss_got", 64'(got), 64'd1);
    check("miss_data", 64'(rd), 64'hDEAD_BEEF);
    check("miss_fill_addr", 64'(fill_addr), 64'h0);
    check("miss_txns", 64'(n_txn - t0), 64'd1);
    check("miss_latency", 64'(cyc), 64'd3);
    t0 = n_txn;
    cpu_req(32'h0000_0010, 1'b0, 32'h0, rd, cyc, got);
    check("hit_data", 64'(rd), 64'hDEAD_BEEF);
    check("hit_latency", 64'(cyc), 64'd2);
    check("hit_no_txn", 64'(n_txn - t0), 64'd0);

    // Write-allocate miss, then read back from the cache.
    t0 = n_txn;
    cpu_req(32'h0000_8004, 1'b1, 32'h1234_5678, rd, cyc, got);
    check("wmiss_got", 64'(got), 64'd1);
    check("wmiss_resp_word", 64'(rd), 64'h1234_5678);
    check("wmiss_fill_addr", 64'(fill_addr), 64'h8000);
    check("wmiss_txns", 64'(n_txn - t0), 64'd1);
    t0 = n_txn;
    cpu_req(32'h0000_8004, 1'b0, 32'h0, rd, cyc, got);
    check("wr_then_rd", 64'(rd), 64'h1234_5678);
    check("wr_then_rd_no_txn", 64'(n_txn - t0), 64'd0);
    check("wr_then_rd_latency", 64'(cyc), 64'd2);

    // Same index, different tag: dirty victim written back before the fill.
    t0 = n_txn;
    cpu_req(32'h0000_8404, 1'b0, 32'h0, rd, cyc, got);
    check("evict_txns", 64'(n_txn - t0), 64'd2);
    check("wb_addr", 64'(wb_addr), 64'h8000);
    check("wb_word1", 64'(wb_data[63:32]), 64'h1234_5678);
    check("wb_word0", 64'(wb_data[31:0]), 64'h5A00_8000);
    check("evict_fill_addr", 64'(fill_addr), 64'h8400);
    check("evict_data", 64'(rd), 64'h5A00_8404);

    // Evicted line comes back from memory with the written word; clean victim.
    t0 = n_txn;
    cpu_req(32'h0000_8004, 1'b0, 32'h0, rd, cyc, got);
    check("refill_data", 64'(rd), 64'h1234_5678);
    check("refill_txns", 64'(n_txn - t0), 64'd1);
    check("refill_fill_addr", 64'(fill_addr), 64'h8000);

    // Write hit, then read of the merged word.
    t0 = n_txn;
    cpu_req(32'h0000_8008, 1'b1, 32'hCAFE_F00D, rd, cyc, got);
    check("whit_latency", 64'(cyc), 64'd2);
    cpu_req(32'h0000_8008, 1'b0, 32'h0, rd, cyc, got);
    check("whit_readback", 64'(rd), 64'hCAFE_F00D);
    cpu_req(32'h0000_8004, 1'b0, 32'h0, rd, cyc, got);
    check("whit_neighbor", 64'(rd), 64'h1234_5678);
    check("whit_no_txn", 64'(n_txn - t0), 64'd0);

    // MMIO window is ignored.
    t0 = n_txn;
    @(negedge clk);
    cpu_addr_valid = 1'b1;
    cpu_addr = 32'h0000_C008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mmio_no_ready", 64'(cpu_read_data_ready === 1'b1), 64'd0);
      check("mmio_no_mem", 64'(mem_addr_valid), 64'd0);
    end
    cpu_addr_valid = 1'b0;
    check("mmio_no_txn", 64'(n_txn - t0), 64'd0);

    // Slow memory: fill acknowledged 7 cycles late.
    mem_delay = 7;
    stab_err = 0;
    t0 = n_txn;
    cpu_req(32'h0000_1040, 1'b0, 32'h0, rd, cyc, got);
    check("slow_got", 64'(got), 64'd1);
    check("slow_data", 64'(rd), 64'h5A00_1040);
    check("slow_latency", 64'(cyc), 64'd10);
    check("slow_stable", 64'(stab_err), 64'd0);
    check("slow_fill_addr", 64'(fill_addr), 64'h1040);
    check("slow_txns", 64'(n_txn - t0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("slow_single_pulse", 64'(cpu_read_data_ready === 1'b1), 64'd0);
    end

    // Reset in the middle of a fill aborts it and empties the cache.
    mem_delay = 20;
    @(negedge clk);
    cpu_addr_valid = 1'b1;
    cpu_addr = 32'h0000_0080;
    repeat (3) @(negedge clk);
    check("fill_active", 64'(mem_addr_valid), 64'd1);
    check("fill_active_addr", 64'(mem_addr), 64'h80);
    rst = 1'b0;
    #1;
    check("rst_drops_valid", 64'(mem_addr_valid), 64'd0);
    check("rst_drops_addr", 64'(mem_addr), 64'd0);
    cpu_addr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_delay = 0;
    t0 = n_txn;
    cpu_req(32'h0000_1040, 1'b0, 32'h0, rd, cyc, got);
    check("post_rst_miss", 64'(n_txn - t0), 64'd1);
    check("post_rst_data", 64'(rd), 64'h5A00_1040);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the hart's 32-bit data port and the 512-bit external memory bus (ROM/RAM).
- Serves word reads and writes from cached 64-byte lines.
- Does not respond to the MMIO timer window, so the timer can answer on the shared CPU response wires.

Parameters:
- NUM_LINES, 16, number of cache lines (power of two ≥2); index width IW = log2(NUM_LINES).
- MMIO_BASE, 32'h0000_C000, base of the 16-byte uncached window the cache ignores.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr_valid  in  1  CPU request present; held until the ready pulse.
- cpu_addr  in  32  byte address; [1:0] ignored (word access only).
- cpu_write_data_valid  in  1  with cpu_addr_valid: request is a write.
- cpu_write_data  in  32  write word.
- cpu_read_data_ready  out  1  one-cycle completion pulse (reads and writes); high-Z when not responding.
- cpu_read_data  out  32  read word, valid with ready; high-Z when not responding.
- mem_addr_valid  out  1  external transaction in progress.
- mem_addr  out  32  64-byte-aligned line address; 0 when mem_addr_valid=0.
- mem_write_data_valid  out  1  current transaction is a line write-back.
- mem_write_data  out  512  victim line; 0 when not writing.
- mem_read_data_ready  in  1  external acknowledge (fill data valid / write accepted).
- mem_read_data  in  512  fill line.

Behaviour:
- Address split:
  - offset word = addr[5:2]; index = addr[6+IW-1:6]; tag = addr[31:6+IW].
  - Word w of a line occupies line bits [32w+31:32w].
- Per-line state: valid, dirty, tag, 512-bit data.
- On reset (async, rst=0): all valid/dirty cleared; FSM→IDLE; mem_* outputs 0; cpu_read_data_ready/cpu_read_data high-Z.
- Reset mid-transaction aborts it; dirty data is discarded.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE:
  - If cpu_addr_valid=1 and cpu_addr[31:4] != MMIO_BASE[31:4]: latch addr, write flag and data → LOOKUP.
  - MMIO-window requests are ignored (stay IDLE, outputs stay Z).
- LOOKUP:
  - Hit (valid and tag match): read returns the word; write merges the word into the line and sets dirty; → RESP.
  - Miss with valid and dirty victim → WRITEBACK.
  - Otherwise → FILL.
- WRITEBACK:
  - mem_addr_valid=1, mem_write_data_valid=1, mem_addr={victim tag, index, 6'b0}, mem_write_data=victim line.
  - Held until mem_read_data_ready=1; then clear dirty → FILL.
- FILL:
  - mem_addr_valid=1, mem_write_data_valid=0, mem_addr={req tag, index, 6'b0}.
  - On mem_read_data_ready=1: install line (valid=1, dirty=0, tag); if write, merge word and set dirty → RESP.
- RESP:
  - Drive cpu_read_data_ready=1 for exactly one cycle; cpu_read_data = word (for writes, the newly written word) → IDLE.
- Latency:
  - Hit: ready pulses 2 cycles after valid sampled in IDLE (IDLE→LOOKUP→RESP).
  - Miss: adds external wait cycles.
- CPU must drop or change its request in the cycle after the ready pulse. A request still held when IDLE samples is treated as new.
- Request inputs are ignored outside IDLE (latched copy used).
- Write to an address then read of the same address returns the new word with no memory traffic.
- Index wrap: addresses differing only in tag map to the same line and evict each other.

Test Plan:
- Reset, then read 0x0000_0010, no prior data → FILL with mem_addr=0x0000_0000. Memory returns line with word4=0xDEADBEEF → one ready pulse, cpu_read_data=0xDEADBEEF. Re-read → hit, no mem_addr_valid, ready 2 cycles after request.
- Write 0x1234_5678 to 0x0000_8004 (miss) → FILL of 0x0000_8000, ready pulse. Read 0x0000_8004 → 0x1234_5678 from cache with no external traffic.
- NUM_LINES=16: after the dirty write above, read 0x0000_8404 (same index, different tag) → WRITEBACK first: mem_addr=0x0000_8000, mem_write_data_valid=1, mem_write_data[63:32]=0x1234_5678. Then FILL of 0x0000_8400.
- Read 0x0000_C008 (MMIO window) for 5 cycles → cpu_read_data_ready stays Z, no mem_addr_valid.
- Deassert rst during FILL → mem_addr_valid falls immediately. Afterwards a read of a previously cached address misses again.
- Delay mem_read_data_ready 7 cycles in FILL → mem_addr and mem_addr_valid held stable throughout; exactly one ready pulse after acknowledge.
